// File: rtl/rsa_sched_pkg.sv
// rtl/rsa_sched_pkg.sv - shared types and defaults for the rsa_unit scheduler
package rsa_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DONE,
      ST_ABORT
   } sched_state_t;

   localparam int REQ_SPI  = 0;
   localparam int REQ_GPIO = 1;

   localparam int DEF_CLR_CYCLES = 2;
   localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/rsa_rr_arb2.sv
// rtl/rsa_rr_arb2.sv - two-way round-robin pick between pending requesters
module rsa_rr_arb2 (
   input  logic [1:0] pending_i,
   input  logic       owner_i,
   output logic [1:0] grant_o,
   output logic       valid_o
);

   // On a tie the requester that did not own the unit last goes next.
   always_comb begin
      grant_o = pending_i;
      if (pending_i == 2'b11) begin
         grant_o = owner_i ? 2'b01 : 2'b10;
      end
   end

   assign valid_o = |pending_i;

endmodule

// File: rtl/rsa_scheduler.sv
// rtl/rsa_scheduler.sv - shares one rsa_unit between the SPI and GPIO requesters
module rsa_scheduler
   import rsa_sched_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CLR_CYCLES = DEF_CLR_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic [1:0]         req_start,
   input  logic [1:0]         req_stop,
   input  logic [2*WIDTH-1:0] req_p,
   input  logic [2*WIDTH-1:0] req_e,
   input  logic [2*WIDTH-1:0] req_m,
   input  logic [2*WIDTH-1:0] req_const,
   output logic               rsa_en,
   output logic               rsa_rstb,
   output logic [WIDTH-1:0]   rsa_p,
   output logic [WIDTH-1:0]   rsa_e,
   output logic [WIDTH-1:0]   rsa_m,
   output logic [WIDTH-1:0]   rsa_const,
   input  logic               rsa_eoc,
   input  logic [WIDTH-1:0]   rsa_c,
   output logic [1:0]         pending,
   output logic               busy,
   output logic               owner,
   output logic [1:0]         done,
   output logic [1:0]         err,
   output logic [WIDTH-1:0]   result,
   output logic               result_id,
   output logic               irq
);

   sched_state_t     state_q;
   logic [1:0]       pending_q, pending_d;
   logic             owner_q;
   logic             rsa_en_q, rsa_rstb_q;
   logic [WIDTH-1:0] rsa_p_q, rsa_e_q, rsa_m_q, rsa_const_q;
   logic [1:0]       done_q, err_q;
   logic [WIDTH-1:0] result_q;
   logic             result_id_q;
   logic [7:0]       clr_cnt_q, tmo_q;

   logic [1:0]       eligible, grant, start_ok;
   logic             grant_vld, take, gsel;

   assign busy     = (state_q != ST_IDLE);
   assign eligible = pending_q & ~req_stop;
   // The running owner cannot queue a second job behind itself.
   assign start_ok = req_start & ~(busy ? (2'b01 << owner_q) : 2'b00);

   rsa_rr_arb2 u_arb (
      .pending_i (eligible),
      .owner_i   (owner_q),
      .grant_o   (grant),
      .valid_o   (grant_vld)
   );

   assign take      = (state_q == ST_IDLE) && ena && grant_vld;
   assign gsel      = grant[REQ_GPIO];
   assign pending_d = (pending_q | start_ok) & ~req_stop & ~(take ? grant : 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         owner_q     <= 1'(REQ_GPIO);
         rsa_en_q    <= 1'b0;
         rsa_rstb_q  <= 1'b0;
         rsa_p_q     <= '0;
         rsa_e_q     <= '0;
         rsa_m_q     <= '0;
         rsa_const_q <= '0;
         done_q      <= '0;
         err_q       <= '0;
         result_q    <= '0;
         result_id_q <= 1'b0;
         clr_cnt_q   <= '0;
         tmo_q       <= '0;
      end else begin
         pending_q <= pending_d;
         done_q    <= '0;
         err_q     <= '0;
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  owner_q     <= gsel;
                  rsa_p_q     <= gsel ? req_p[REQ_GPIO*WIDTH +: WIDTH]     : req_p[REQ_SPI*WIDTH +: WIDTH];
                  rsa_e_q     <= gsel ? req_e[REQ_GPIO*WIDTH +: WIDTH]     : req_e[REQ_SPI*WIDTH +: WIDTH];
                  rsa_m_q     <= gsel ? req_m[REQ_GPIO*WIDTH +: WIDTH]     : req_m[REQ_SPI*WIDTH +: WIDTH];
                  rsa_const_q <= gsel ? req_const[REQ_GPIO*WIDTH +: WIDTH] : req_const[REQ_SPI*WIDTH +: WIDTH];
                  clr_cnt_q   <= '0;
                  tmo_q       <= '0;
                  rsa_en_q    <= 1'b0;
                  rsa_rstb_q  <= 1'b0;
                  state_q     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (req_stop[owner_q]) begin
                  rsa_rstb_q      <= 1'b0;
                  rsa_en_q        <= 1'b0;
                  done_q[owner_q] <= 1'b1;
                  err_q[owner_q]  <= 1'b1;
                  state_q         <= ST_ABORT;
               end else if (clr_cnt_q == 8'(CLR_CYCLES - 1)) begin
                  rsa_rstb_q <= 1'b1;
                  rsa_en_q   <= 1'b1;
                  state_q    <= ST_RUN;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 8'd1;
               end
            end
            ST_RUN: begin
               // A result arriving together with a stop is still delivered.
               if (rsa_eoc) begin
                  result_q        <= rsa_c;
                  result_id_q     <= owner_q;
                  done_q[owner_q] <= 1'b1;
                  rsa_en_q        <= 1'b0;
                  state_q         <= ST_DONE;
               end else if (req_stop[owner_q] || (tmo_q == 8'(TIMEOUT - 1))) begin
                  rsa_rstb_q      <= 1'b0;
                  rsa_en_q        <= 1'b0;
                  done_q[owner_q] <= 1'b1;
                  err_q[owner_q]  <= 1'b1;
                  state_q         <= ST_ABORT;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pending   = pending_q;
   assign owner     = owner_q;
   assign rsa_en    = rsa_en_q;
   assign rsa_rstb  = rsa_rstb_q;
   assign rsa_p     = rsa_p_q;
   assign rsa_e     = rsa_e_q;
   assign rsa_m     = rsa_m_q;
   assign rsa_const = rsa_const_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign result_id = result_id_q;
   assign irq       = |done_q;

endmodule

// File: tb/tb_rsa_scheduler.sv
// tb/tb_rsa_scheduler.sv - bench for rsa_scheduler against a job-level reference model
module tb_rsa_scheduler;

   localparam int W   = 8;
   localparam int CLR = 2;
   localparam int TMO = 20;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ena = 1'b0;
   logic [1:0]     req_start = '0, req_stop = '0;
   logic [2*W-1:0] req_p = '0, req_e = '0, req_m = '0, req_const = '0;
   logic           rsa_en, rsa_rstb;
   logic [W-1:0]   rsa_p, rsa_e, rsa_m, rsa_const;
   logic           rsa_eoc = 1'b0;
   logic [W-1:0]   rsa_c = '0;
   logic [1:0]     pending, done, err;
   logic           busy, owner, result_id, irq;
   logic [W-1:0]   result;

   int checks = 0;
   int errors = 0;

   rsa_scheduler #(.WIDTH(W), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .req_start(req_start), .req_stop(req_stop),
      .req_p(req_p), .req_e(req_e), .req_m(req_m), .req_const(req_const),
      .rsa_en(rsa_en), .rsa_rstb(rsa_rstb),
      .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
      .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
      .pending(pending), .busy(busy), .owner(owner),
      .done(done), .err(err), .result(result), .result_id(result_id), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] modexp(logic [W-1:0] p, logic [W-1:0] e, logic [W-1:0] m);
      int r;
      if (p == 0) return '0;
      r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * int'(m)) % int'(p);
      return W'(r % int'(p));
   endfunction

   // rsa_unit stub: eoc on the stub_k-th enabled cycle, C = M^E mod P
   int stub_k   = 10;
   int stub_cnt = 0;
   bit no_eoc   = 1'b0;
   always @(negedge clk) begin
      if (rsa_en) stub_cnt++; else stub_cnt = 0;
      rsa_eoc = rsa_en && !no_eoc && (stub_cnt == stub_k);
      rsa_c   = modexp(rsa_p, rsa_e, rsa_m);
   end

   // Reference model: a job is tracked by its age in cycles since grant, plus a one-cycle tail
   logic [1:0]   m_pend, m_done, m_err;
   logic         m_owner, m_rstb, m_rid;
   logic [W-1:0] m_p, m_e, m_m, m_c, m_result;
   int           m_age, m_tail;

   task automatic m_abort();
      m_done[m_owner] = 1'b1;
      m_err[m_owner]  = 1'b1;
      m_tail = 2;
      m_age  = 0;
      m_rstb = 1'b0;
   endtask

   task automatic model_step();
      logic [1:0] elig, set, gmask;
      bit         mbusy;
      int         g;
      mbusy = (m_age != 0) || (m_tail != 0);
      elig  = m_pend & ~req_stop;
      g = -1;
      if (!mbusy && ena && elig != 2'b00)
         g = (elig == 2'b11) ? (m_owner ? 0 : 1) : (elig[1] ? 1 : 0);
      set = req_start;
      if (mbusy) set[m_owner] = 1'b0;
      gmask = 2'b00;
      if (g >= 0) gmask[g] = 1'b1;
      m_pend = (m_pend | set) & ~req_stop & ~gmask;
      m_done = 2'b00;
      m_err  = 2'b00;
      if (m_tail != 0) begin
         m_tail = 0;
      end else if (m_age != 0) begin
         if (m_age <= CLR) begin
            if (req_stop[m_owner]) m_abort();
            else begin
               m_age++;
               if (m_age == CLR + 1) m_rstb = 1'b1;
            end
         end else if (rsa_eoc) begin
            m_result = modexp(m_p, m_e, m_m);
            m_rid    = m_owner;
            m_done[m_owner] = 1'b1;
            m_tail = 1;
            m_age  = 0;
         end else if (req_stop[m_owner] || (m_age - CLR == TMO)) begin
            m_abort();
         end else begin
            m_age++;
         end
      end else if (g >= 0) begin
         m_owner = g[0];
         m_p = req_p[g*W +: W];
         m_e = req_e[g*W +: W];
         m_m = req_m[g*W +: W];
         m_c = req_const[g*W +: W];
         m_age  = 1;
         m_rstb = 1'b0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = '0; m_done = '0; m_err = '0;
         m_owner = 1'b1; m_rstb = 1'b0; m_rid = 1'b0;
         m_p = '0; m_e = '0; m_m = '0; m_c = '0; m_result = '0;
         m_age = 0; m_tail = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("pending",   pending,   m_pend);
         chk("busy",      busy,      (m_age != 0) || (m_tail != 0));
         chk("owner",     owner,     m_owner);
         chk("done",      done,      m_done);
         chk("err",       err,       m_err);
         chk("irq",       irq,       |m_done);
         chk("result",    result,    m_result);
         chk("result_id", result_id, m_rid);
         chk("rsa_en",    rsa_en,    m_age > CLR);
         chk("rsa_rstb",  rsa_rstb,  m_rstb);
         chk("rsa_p",     rsa_p,     m_p);
         chk("rsa_e",     rsa_e,     m_e);
         chk("rsa_m",     rsa_m,     m_m);
         chk("rsa_const", rsa_const, m_c);
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; req_start = '0; req_stop = '0; no_eoc = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done == 2'b00 && n < 200) begin cyc(1); n++; end
   endtask

   task automatic wait_en(output int n);
      n = 0;
      while (!rsa_en && n < 50) begin cyc(1); n++; end
   endtask

   int n, irqs;

   initial begin
      // reset state and single request: 4^3 mod 11 = 9
      do_reset();
      chk("rst_owner", owner, 1);
      chk("rst_rstb", rsa_rstb, 0);
      chk("rst_pending", pending, 0);
      ena = 1'b1; stub_k = 10;
      req_p = {8'd7, 8'd11}; req_e = {8'd3, 8'd3}; req_m = {8'd3, 8'd4}; req_const = {8'd66, 8'd77};
      req_start = 2'b01; cyc(1); req_start = 2'b00;
      wait_en(n);
      chk("t1_en_latency", n, 3);
      wait_done(n);
      chk("t1_done", done, 2'b01);
      chk("t1_err", err, 2'b00);
      chk("t1_result", result, 9);
      chk("t1_result_id", result_id, 0);
      irqs = int'(irq);
      for (int i = 0; i < 5; i++) begin cyc(1); irqs += int'(irq); end
      chk("t1_irq_pulses", irqs, 1);

      // simultaneous starts: 5^2 mod 13 = 12 for requester 0, 3^3 mod 7 = 6 for requester 1
      do_reset();
      ena = 1'b1; stub_k = 6;
      req_p = {8'd7, 8'd13}; req_e = {8'd3, 8'd2}; req_m = {8'd3, 8'd5};
      req_start = 2'b11; cyc(1); req_start = 2'b00;
      wait_done(n);
      chk("t2_first_done", done, 2'b01);
      chk("t2_first_result", result, 12);
      cyc(1);
      wait_done(n);
      chk("t2_second_done", done, 2'b10);
      chk("t2_second_result", result, 6);
      chk("t2_second_id", result_id, 1);

      // owner stop during RUN
      cyc(2); stub_k = 15;
      req_start = 2'b01; cyc(1); req_start = 2'b00;
      wait_en(n); cyc(3);
      req_stop = 2'b01; cyc(1); req_stop = 2'b00;
      chk("t3_done", done, 2'b01);
      chk("t3_err", err, 2'b01);
      chk("t3_rstb", rsa_rstb, 0);
      chk("t3_result_kept", result, 6);
      cyc(1);
      chk("t3_idle", busy, 0);

      // timeout on RUN cycle TMO, then the queued requester is granted
      no_eoc = 1'b1;
      req_start = 2'b01; cyc(1); req_start = 2'b10; cyc(1); req_start = 2'b00;
      chk("t4_queued", pending, 2'b10);
      wait_en(n);
      n = 0;
      while (rsa_en && n < 100) begin n++; cyc(1); end
      chk("t4_run_cycles", n, TMO);
      chk("t4_err", err, 2'b01);
      no_eoc = 1'b0; stub_k = 4;
      cyc(2);
      chk("t4_next_owner", owner, 1);
      chk("t4_next_busy", busy, 1);
      wait_done(n);
      chk("t4_next_done", done, 2'b10);
      chk("t4_next_err", err, 2'b00);

      // start+stop together, and a non-owner stop while the owner runs
      cyc(2); stub_k = 8;
      req_start = 2'b01; req_stop = 2'b01; cyc(1); req_start = 2'b00; req_stop = 2'b00;
      chk("t5_no_pending", pending, 0);
      cyc(2);
      chk("t5_no_grant", busy, 0);
      req_start = 2'b01; cyc(1); req_start = 2'b10; cyc(1); req_start = 2'b00;
      chk("t5_other_pending", pending, 2'b10);
      req_stop = 2'b10; cyc(1); req_stop = 2'b00;
      chk("t5_other_cleared", pending, 2'b00);
      wait_done(n);
      chk("t5_done", done, 2'b01);
      chk("t5_err", err, 2'b00);
      cyc(3);
      chk("t5_stays_idle", busy, 0);

      // asynchronous reset mid-RUN, then ena gating
      req_start = 2'b01; cyc(1); req_start = 2'b00;
      wait_en(n); cyc(2);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_en", rsa_en, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_owner", owner, 1);
      chk("t6_rst_result", result, 0);
      chk("t6_rst_p", rsa_p, 0);
      cyc(1); rst = 1'b0; ena = 1'b0;
      req_start = 2'b01; cyc(1); req_start = 2'b00;
      cyc(4);
      chk("t6_blocked_busy", busy, 0);
      chk("t6_blocked_pending", pending, 2'b01);
      ena = 1'b1; cyc(1);
      chk("t6_granted", busy, 1);
      wait_done(n);
      cyc(2);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         ena = ($urandom_range(0, 9) != 0);
         req_start[0] = ($urandom_range(0, 5) == 0);
         req_start[1] = ($urandom_range(0, 5) == 0);
         req_stop[0]  = ($urandom_range(0, 29) == 0);
         req_stop[1]  = ($urandom_range(0, 29) == 0);
         req_p = 16'($urandom); req_e = 16'($urandom); req_m = 16'($urandom); req_const = 16'($urandom);
         if (!rsa_en) stub_k = $urandom_range(1, 25);
         cyc(1);
      end
      req_start = '0; req_stop = '0; ena = 1'b1;
      cyc(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
